// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_ctrl_pkg;

  // Per-stage pipeline register write control
  typedef logic [1:0] wctl_t;

  localparam wctl_t WR_LOAD  = 2'b00;
  localparam wctl_t WR_FLUSH = 2'b01;
  localparam wctl_t WR_HOLD  = 2'b10;

  typedef enum logic [1:0] {
    HZ_IDLE  = 2'b00,
    HZ_MULTI = 2'b01,
    HZ_PEND  = 2'b10
  } hz_state_t;

  // True when the instruction in E writes a register that D reads
  function automatic logic load_use_hit(input logic       is_load,
                                        input logic [4:0] rd,
                                        input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return is_load && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline event inputs and per-stage control outputs
interface hazard_ctrl_if #(
  parameter int XLEN = 64
);
  import hazard_ctrl_pkg::*;

  logic            i_busy;
  logic            d_busy;
  logic [4:0]      d_rs1;
  logic [4:0]      d_rs2;
  logic [4:0]      e_rd;
  logic            e_is_load;
  logic            e_multi;
  logic            e_redirect;
  logic [XLEN-1:0] e_target;

  wctl_t           FWrite;
  wctl_t           DWrite;
  wctl_t           EWrite;
  wctl_t           MWrite;
  wctl_t           WWrite;
  logic            pc_sel;
  logic [XLEN-1:0] pc_target;

  // Pipeline side: reports events, consumes stage controls
  modport master (
    output i_busy, d_busy, d_rs1, d_rs2, e_rd, e_is_load, e_multi, e_redirect, e_target,
    input  FWrite, DWrite, EWrite, MWrite, WWrite, pc_sel, pc_target
  );

  // Hazard controller side
  modport slave (
    input  i_busy, d_busy, d_rs1, d_rs2, e_rd, e_is_load, e_multi, e_redirect, e_target,
    output FWrite, DWrite, EWrite, MWrite, WWrite, pc_sel, pc_target
  );

endinterface

// File: rtl/hazard_ctrl_muldiv_timer.sv
// rtl/hazard_ctrl_muldiv_timer.sv - down-counter tracking remaining mul/div occupancy of E
module muldiv_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  input  logic         freeze_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Freeze wins over everything so a memory stall stretches the op exactly
  always_comb begin
    count_d = count_q;
    if (!freeze_i) begin
      if (load_i) begin
        count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush scheduler for the five-stage pipeline
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int XLEN       = 64
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  localparam int CNT_W = $clog2(MULDIV_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MULDIV_LAT - 2);

  hz_state_t       state_q;
  hz_state_t       state_d;
  logic [XLEN-1:0] tgt_q;
  logic [XLEN-1:0] tgt_d;

  logic t_load;
  logic t_dec;
  logic t_zero;
  logic load_use;
  logic multi_stall;

  // The first cycle of a multi-cycle op holds E itself, so the counter
  // starts two short of the latency to give MULDIV_LAT cycles in total.
  muldiv_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (t_load),
    .load_val_i (CNT_START),
    .dec_i      (t_dec),
    .freeze_i   (hz.d_busy),
    .zero_o     (t_zero)
  );

  assign load_use    = load_use_hit(hz.e_is_load, hz.e_rd, hz.d_rs1, hz.d_rs2);
  assign multi_stall = ((state_q == HZ_MULTI) && !t_zero) ||
                       ((state_q == HZ_IDLE) && hz.e_multi);

  // Priority mux of stage controls plus FSM next state
  always_comb begin
    hz.FWrite    = WR_LOAD;
    hz.DWrite    = WR_LOAD;
    hz.EWrite    = WR_LOAD;
    hz.MWrite    = WR_LOAD;
    hz.WWrite    = WR_LOAD;
    hz.pc_sel    = 1'b0;
    hz.pc_target = (state_q == HZ_PEND) ? tgt_q : hz.e_target;
    state_d      = state_q;
    tgt_d        = tgt_q;
    t_load       = 1'b0;
    t_dec        = 1'b0;

    if (reset) begin
      hz.FWrite = WR_FLUSH;
      hz.DWrite = WR_FLUSH;
      hz.EWrite = WR_FLUSH;
      hz.MWrite = WR_FLUSH;
      hz.WWrite = WR_FLUSH;
    end else if (hz.d_busy) begin
      // Whole pipe waits on memory; bubble into W. State and counter freeze.
      hz.FWrite = WR_HOLD;
      hz.DWrite = WR_HOLD;
      hz.EWrite = WR_HOLD;
      hz.MWrite = WR_HOLD;
      hz.WWrite = WR_FLUSH;
    end else if (multi_stall) begin
      hz.FWrite = WR_HOLD;
      hz.DWrite = WR_HOLD;
      hz.EWrite = WR_HOLD;
      hz.MWrite = WR_FLUSH;
      if (state_q == HZ_IDLE) begin
        state_d = HZ_MULTI;
        t_load  = 1'b1;
      end else begin
        t_dec = 1'b1;
      end
    end else if (load_use) begin
      hz.FWrite = WR_HOLD;
      hz.DWrite = WR_HOLD;
      hz.EWrite = WR_FLUSH;
      if (state_q == HZ_MULTI) begin
        state_d = HZ_IDLE;
      end
    end else if (state_q == HZ_PEND) begin
      // Whatever fetch returns is wrong-path; redirect once fetch is free
      hz.DWrite = WR_FLUSH;
      if (hz.i_busy) begin
        hz.FWrite = WR_HOLD;
      end else begin
        hz.pc_sel = 1'b1;
        state_d   = HZ_IDLE;
      end
    end else begin
      // IDLE, or MULTI releasing E this cycle
      state_d = HZ_IDLE;
      if (hz.e_redirect) begin
        hz.DWrite = WR_FLUSH;
        hz.EWrite = WR_FLUSH;
        if (hz.i_busy) begin
          hz.FWrite = WR_HOLD;
          tgt_d     = hz.e_target;
          state_d   = HZ_PEND;
        end else begin
          hz.pc_sel = 1'b1;
        end
      end else if (hz.i_busy) begin
        hz.FWrite = WR_HOLD;
        hz.DWrite = WR_FLUSH;
      end
    end
  end

  // FSM state and deferred redirect target
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HZ_IDLE;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

endmodule
